// File: rtl/pipe_control.sv
// Control unit for the 4-bit-opcode filter pipeline: decodes in ID, carries
// control through ID/EX, EX/MEM and MEM/WB, and resolves RAW hazards and taken branches.
module pipe_control #(
    parameter int REG_AW = 4,
    parameter bit FWD_EN = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [3:0]        opcode_i,
    input  logic [REG_AW-1:0] rd_i,
    input  logic [REG_AW-1:0] ra_i,
    input  logic [REG_AW-1:0] rb_i,
    input  logic              br_cond_i,
    output logic              re_a_o,
    output logic              re_b_o,
    output logic              stall_o,
    output logic              flush_o,
    output logic              illegal_o,
    output logic [2:0]        ex_alu_ctrl,
    output logic [1:0]        ex_sel_b,
    output logic [1:0]        ex_fwd_a,
    output logic [1:0]        ex_fwd_b,
    output logic              mem_we_o,
    output logic              mem_re_o,
    output logic [1:0]        wb_sel_data,
    output logic              wb_reg_we,
    output logic [REG_AW-1:0] wb_rd
);

    typedef struct packed {
        logic              valid;
        logic [2:0]        aluCtrl;
        logic [1:0]        selB;
        logic [1:0]        selData;
        logic              memWe;
        logic              memRe;
        logic              regWe;
        logic              isBt;
        logic              isLd;
        logic [REG_AW-1:0] rd;
        logic [1:0]        fwdA;
        logic [1:0]        fwdB;
    } exCtrl_t;

    typedef struct packed {
        logic              valid;
        logic [1:0]        selData;
        logic              memWe;
        logic              memRe;
        logic              regWe;
        logic [REG_AW-1:0] rd;
    } memCtrl_t;

    exCtrl_t           idCtrl;
    exCtrl_t           exCtrl_d;
    exCtrl_t           exCtrl_q;
    memCtrl_t          memCtrl_d;
    memCtrl_t          memCtrl_q;
    logic [1:0]        wbSelData_q;
    logic              wbRegWe_q;
    logic [REG_AW-1:0] wbRd_q;

    logic       reA;
    logic       reB;
    logic       illegal;
    logic       matchExA;
    logic       matchExB;
    logic       matchMemA;
    logic       matchMemB;
    logic       flush;
    logic       stall;
    logic [1:0] fwdA;
    logic [1:0] fwdB;

    // rd is only kept for writers, so non-writing instructions carry a zero destination.
    always_comb begin
        idCtrl  = '0;
        reA     = 1'b0;
        reB     = 1'b0;
        illegal = 1'b0;
        if (valid_i) begin
            idCtrl.valid = 1'b1;
            reA          = 1'b1;
            reB          = 1'b1;
            case (opcode_i)
                4'b1000: idCtrl.aluCtrl = 3'b001;
                4'b1001, 4'b1010: begin
                    illegal = 1'b1;
                    reA     = 1'b0;
                    reB     = 1'b0;
                end
                4'b1011: begin
                    idCtrl.selData = 2'd1;
                    idCtrl.regWe   = 1'b1;
                    reA            = 1'b0;
                    reB            = 1'b0;
                end
                4'b1100: begin
                    idCtrl.selB    = 2'd1;
                    idCtrl.memRe   = 1'b1;
                    idCtrl.selData = 2'd2;
                    idCtrl.regWe   = 1'b1;
                    idCtrl.isLd    = 1'b1;
                    reB            = 1'b0;
                end
                4'b1101: begin
                    idCtrl.selB  = 2'd2;
                    idCtrl.memWe = 1'b1;
                end
                4'b1110: begin
                    idCtrl.isBt = 1'b1;
                    reA         = 1'b0;
                    reB         = 1'b0;
                end
                4'b1111: begin
                    reA = 1'b0;
                    reB = 1'b0;
                end
                default: begin
                    idCtrl.aluCtrl = opcode_i[2:0];
                    idCtrl.regWe   = 1'b1;
                    if (opcode_i == 4'b0110) begin
                        reB = 1'b0;
                    end
                end
            endcase
            if (idCtrl.regWe) begin
                idCtrl.rd = rd_i;
            end
        end
    end

    // The instruction now in EX will sit in EX/MEM when the ID instruction reaches EX.
    always_comb begin
        matchExA  = reA && exCtrl_q.valid && exCtrl_q.regWe && (exCtrl_q.rd == ra_i);
        matchExB  = reB && exCtrl_q.valid && exCtrl_q.regWe && (exCtrl_q.rd == rb_i);
        matchMemA = reA && memCtrl_q.valid && memCtrl_q.regWe && (memCtrl_q.rd == ra_i);
        matchMemB = reB && memCtrl_q.valid && memCtrl_q.regWe && (memCtrl_q.rd == rb_i);
        flush     = exCtrl_q.valid && exCtrl_q.isBt && br_cond_i;
        stall     = 1'b0;
        fwdA      = 2'd0;
        fwdB      = 2'd0;
        if (FWD_EN) begin
            stall = exCtrl_q.isLd && (matchExA || matchExB) && !flush;
            if (matchExA) begin
                fwdA = 2'd1;
            end else if (matchMemA) begin
                fwdA = 2'd2;
            end
            if (matchExB) begin
                fwdB = 2'd1;
            end else if (matchMemB) begin
                fwdB = 2'd2;
            end
        end else begin
            stall = (matchExA || matchExB || matchMemA || matchMemB) && !flush;
        end
    end

    always_comb begin
        exCtrl_d      = idCtrl;
        exCtrl_d.fwdA = fwdA;
        exCtrl_d.fwdB = fwdB;
        if (stall || flush) begin
            exCtrl_d = '0;
        end
        memCtrl_d.valid   = exCtrl_q.valid;
        memCtrl_d.selData = exCtrl_q.selData;
        memCtrl_d.memWe   = exCtrl_q.memWe;
        memCtrl_d.memRe   = exCtrl_q.memRe;
        memCtrl_d.regWe   = exCtrl_q.regWe;
        memCtrl_d.rd      = exCtrl_q.rd;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            exCtrl_q    <= '0;
            memCtrl_q   <= '0;
            wbSelData_q <= '0;
            wbRegWe_q   <= 1'b0;
            wbRd_q      <= '0;
        end else begin
            exCtrl_q    <= exCtrl_d;
            memCtrl_q   <= memCtrl_d;
            wbSelData_q <= memCtrl_q.selData;
            wbRegWe_q   <= memCtrl_q.regWe;
            wbRd_q      <= memCtrl_q.rd;
        end
    end

    assign re_a_o      = reA;
    assign re_b_o      = reB;
    assign illegal_o   = illegal;
    assign stall_o     = stall;
    assign flush_o     = flush;
    assign ex_alu_ctrl = exCtrl_q.aluCtrl;
    assign ex_sel_b    = exCtrl_q.selB;
    assign ex_fwd_a    = exCtrl_q.fwdA;
    assign ex_fwd_b    = exCtrl_q.fwdB;
    assign mem_we_o    = memCtrl_q.memWe;
    assign mem_re_o    = memCtrl_q.memRe;
    assign wb_sel_data = wbSelData_q;
    assign wb_reg_we   = wbRegWe_q;
    assign wb_rd       = wbRd_q;

endmodule

// File: tb/tb_pipe_control.sv
// Scoreboard bench for pipe_control: an instruction-level model predicts every
// cycle's outputs for a forwarding and a stall-only instance.
module tb_pipe_control;

    typedef struct packed {
        logic       v;
        logic [3:0] op;
        logic [3:0] rd;
        logic [3:0] ra;
        logic [3:0] rb;
        logic [1:0] fa;
        logic [1:0] fb;
    } instr_t;

    typedef struct packed {
        logic       sel;
        logic       reA;
        logic       reB;
        logic       stall;
        logic       flush;
        logic       illegal;
        logic [2:0] alu;
        logic [1:0] selB;
        logic [1:0] fa;
        logic [1:0] fb;
        logic       memWe;
        logic       memRe;
        logic [1:0] wbSel;
        logic       wbWe;
        logic [3:0] wbRd;
    } snap_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       valid_i = 1'b0;
    logic [3:0] opcode_i = '0;
    logic [3:0] rd_i = '0;
    logic [3:0] ra_i = '0;
    logic [3:0] rb_i = '0;
    logic       br_cond_i = 1'b0;

    logic [1:0]      reA, reB, stallO, flushO, illegalO, memWeO, memReO, wbWeO;
    logic [1:0][2:0] exAlu;
    logic [1:0][1:0] exSelB, exFa, exFb, wbSel;
    logic [1:0][3:0] wbRd;

    always #5 clk = ~clk;

    pipe_control #(.REG_AW(4), .FWD_EN(1'b1)) dutFwd (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .opcode_i(opcode_i),
        .rd_i(rd_i), .ra_i(ra_i), .rb_i(rb_i), .br_cond_i(br_cond_i),
        .re_a_o(reA[1]), .re_b_o(reB[1]), .stall_o(stallO[1]), .flush_o(flushO[1]),
        .illegal_o(illegalO[1]), .ex_alu_ctrl(exAlu[1]), .ex_sel_b(exSelB[1]),
        .ex_fwd_a(exFa[1]), .ex_fwd_b(exFb[1]), .mem_we_o(memWeO[1]), .mem_re_o(memReO[1]),
        .wb_sel_data(wbSel[1]), .wb_reg_we(wbWeO[1]), .wb_rd(wbRd[1])
    );

    pipe_control #(.REG_AW(4), .FWD_EN(1'b0)) dutStall (
        .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .opcode_i(opcode_i),
        .rd_i(rd_i), .ra_i(ra_i), .rb_i(rb_i), .br_cond_i(br_cond_i),
        .re_a_o(reA[0]), .re_b_o(reB[0]), .stall_o(stallO[0]), .flush_o(flushO[0]),
        .illegal_o(illegalO[0]), .ex_alu_ctrl(exAlu[0]), .ex_sel_b(exSelB[0]),
        .ex_fwd_a(exFa[0]), .ex_fwd_b(exFb[0]), .mem_we_o(memWeO[0]), .mem_re_o(memReO[0]),
        .wb_sel_data(wbSel[0]), .wb_reg_we(wbWeO[0]), .wb_rd(wbRd[0])
    );

    snap_t  expQ[$];
    instr_t exS = '0;
    instr_t memS = '0;
    instr_t wbS = '0;
    bit     phaseFwd = 1'b1;
    bit     lastStall = 1'b0;
    bit     lastFlush = 1'b0;
    int     nChecks = 0;
    int     nFail = 0;

    function automatic bit isIllegal(input logic [3:0] op);
        return (op == 4'd9) || (op == 4'd10);
    endfunction

    function automatic bit writesReg(input logic [3:0] op);
        return (op < 4'd8) || (op == 4'd11) || (op == 4'd12);
    endfunction

    function automatic bit readsA(input logic [3:0] op);
        return !((op == 4'd11) || (op == 4'd14) || (op == 4'd15) || isIllegal(op));
    endfunction

    function automatic bit readsB(input logic [3:0] op);
        return !((op == 4'd6) || (op == 4'd11) || (op == 4'd12) || (op == 4'd14) ||
                 (op == 4'd15) || isIllegal(op));
    endfunction

    function automatic logic [2:0] aluOf(input logic [3:0] op);
        if (op < 4'd8) return op[2:0];
        if (op == 4'd8) return 3'd1;
        return 3'd0;
    endfunction

    function automatic logic [1:0] selBOf(input logic [3:0] op);
        if (op == 4'd12) return 2'd1;
        if (op == 4'd13) return 2'd2;
        return 2'd0;
    endfunction

    function automatic logic [1:0] selDataOf(input logic [3:0] op);
        if (op == 4'd11) return 2'd1;
        if (op == 4'd12) return 2'd2;
        return 2'd0;
    endfunction

    function automatic bit hits(input instr_t p, input logic [3:0] r);
        return p.v && writesReg(p.op) && (p.rd == r);
    endfunction

    function automatic snap_t actual(input bit s);
        snap_t a;
        a.sel     = s;
        a.reA     = reA[s];
        a.reB     = reB[s];
        a.stall   = stallO[s];
        a.flush   = flushO[s];
        a.illegal = illegalO[s];
        a.alu     = exAlu[s];
        a.selB    = exSelB[s];
        a.fa      = exFa[s];
        a.fb      = exFb[s];
        a.memWe   = memWeO[s];
        a.memRe   = memReO[s];
        a.wbSel   = wbSel[s];
        a.wbWe    = wbWeO[s];
        a.wbRd    = wbRd[s];
        return a;
    endfunction

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s at %0t: actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    // One cycle: drive ID, predict this cycle's outputs, then advance the model at the edge.
    task automatic applyStimulus(input bit rstn, input bit v, input logic [3:0] op,
                                 input logic [3:0] rd, input logic [3:0] ra,
                                 input logic [3:0] rb, input bit br);
        snap_t  e;
        instr_t id;
        bit     aA, aB, st, fl;
        logic [1:0] fa, fb;
        rst_n = rstn; valid_i = v; opcode_i = op;
        rd_i = rd; ra_i = ra; rb_i = rb; br_cond_i = br;
        aA = v && readsA(op);
        aB = v && readsB(op);
        fl = exS.v && (exS.op == 4'd14) && br;
        fa = 2'd0;
        fb = 2'd0;
        if (phaseFwd) begin
            st = exS.v && (exS.op == 4'd12) && ((aA && hits(exS, ra)) || (aB && hits(exS, rb)));
            if (aA && hits(exS, ra)) fa = 2'd1;
            else if (aA && hits(memS, ra)) fa = 2'd2;
            if (aB && hits(exS, rb)) fb = 2'd1;
            else if (aB && hits(memS, rb)) fb = 2'd2;
        end else begin
            st = (aA && (hits(exS, ra) || hits(memS, ra))) || (aB && (hits(exS, rb) || hits(memS, rb)));
        end
        if (fl) st = 1'b0;
        e.sel     = phaseFwd;
        e.reA     = aA;
        e.reB     = aB;
        e.stall   = st;
        e.flush   = fl;
        e.illegal = v && isIllegal(op);
        e.alu     = exS.v ? aluOf(exS.op) : 3'd0;
        e.selB    = exS.v ? selBOf(exS.op) : 2'd0;
        e.fa      = exS.v ? exS.fa : 2'd0;
        e.fb      = exS.v ? exS.fb : 2'd0;
        e.memWe   = memS.v && (memS.op == 4'd13);
        e.memRe   = memS.v && (memS.op == 4'd12);
        e.wbSel   = wbS.v ? selDataOf(wbS.op) : 2'd0;
        e.wbWe    = wbS.v && writesReg(wbS.op);
        e.wbRd    = e.wbWe ? wbS.rd : 4'd0;
        expQ.push_back(e);
        @(posedge clk);
        if (!rstn) begin
            exS = '0; memS = '0; wbS = '0;
        end else begin
            wbS  = memS;
            memS = exS;
            id   = '0;
            if (v && !st && !fl) begin
                id.v = 1'b1; id.op = op; id.rd = rd; id.ra = ra; id.rb = rb;
                id.fa = fa; id.fb = fb;
            end
            exS = id;
        end
        lastStall = st;
        lastFlush = fl;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
    endtask

    // Upstream holds the ID instruction while the pipe stalls; stalls never exceed two cycles.
    task automatic issue(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] ra,
                         input logic [3:0] rb, input bit br);
        int n;
        n = 0;
        do begin
            applyStimulus(1'b1, 1'b1, op, rd, ra, rb, br);
            n++;
        end while (lastStall && n < 4);
        checkOutput("stallBound", 16'(lastStall), 16'h0);
    endtask

    task automatic runDirected();
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        idle(1);
        issue(4'd0, 4'd1, 4'd2, 4'd3, 1'b0);
        issue(4'd1, 4'd2, 4'd1, 4'd1, 1'b0);
        issue(4'd3, 4'd6, 4'd1, 4'd2, 1'b0);
        idle(3);
        issue(4'd12, 4'd3, 4'd0, 4'd0, 1'b0);
        issue(4'd0, 4'd4, 4'd3, 4'd5, 1'b0);
        idle(3);
        issue(4'd0, 4'd7, 4'd1, 4'd1, 1'b0);
        issue(4'd14, 4'd0, 4'd0, 4'd0, 1'b0);
        issue(4'd12, 4'd8, 4'd7, 4'd0, 1'b1);
        idle(3);
        issue(4'd0, 4'd7, 4'd1, 4'd1, 1'b0);
        issue(4'd14, 4'd0, 4'd0, 4'd0, 1'b0);
        issue(4'd12, 4'd8, 4'd7, 4'd0, 1'b0);
        idle(3);
        issue(4'd10, 4'd5, 4'd1, 4'd2, 1'b0);
        issue(4'd6, 4'd5, 4'd1, 4'd2, 1'b0);
        issue(4'd11, 4'd5, 4'd1, 4'd2, 1'b0);
        issue(4'd15, 4'd5, 4'd1, 4'd2, 1'b0);
        issue(4'd8, 4'd5, 4'd1, 4'd2, 1'b0);
        idle(3);
        issue(4'd0, 4'd1, 4'd2, 4'd3, 1'b0);
        issue(4'd12, 4'd4, 4'd5, 4'd6, 1'b0);
        issue(4'd13, 4'd0, 4'd7, 4'd8, 1'b0);
        applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
        idle(3);
    endtask

    task automatic runRandom(input int cycles);
        logic [3:0] hOp, hRd, hRa, hRb;
        hOp = '0; hRd = '0; hRa = '0; hRb = '0;
        for (int i = 0; i < cycles; i++) begin
            if ($urandom_range(0, 63) == 0) begin
                applyStimulus(1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0);
            end else if (lastFlush) begin
                applyStimulus(1'b1, 1'b0, 4'd0, 4'd0, 4'd0, 4'd0, 1'($urandom_range(0, 1)));
            end else if (lastStall) begin
                applyStimulus(1'b1, 1'b1, hOp, hRd, hRa, hRb, 1'($urandom_range(0, 1)));
            end else begin
                hOp = 4'($urandom_range(0, 15));
                hRd = 4'($urandom_range(0, 3));
                hRa = 4'($urandom_range(0, 3));
                hRb = 4'($urandom_range(0, 3));
                applyStimulus(1'b1, 1'($urandom_range(0, 4) != 0), hOp, hRd, hRa, hRb,
                              1'($urandom_range(0, 1)));
            end
        end
    endtask

    // Monitor: pops one predicted snapshot per cycle and compares away from the clock edge.
    initial begin
        snap_t e, a;
        forever begin
            @(negedge clk);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                a = actual(e.sel);
                checkOutput("idComb", 16'({a.reA, a.reB, a.stall, a.flush, a.illegal}),
                            16'({e.reA, e.reB, e.stall, e.flush, e.illegal}));
                checkOutput("exCtrl", 16'({a.alu, a.selB, a.fa, a.fb}),
                            16'({e.alu, e.selB, e.fa, e.fb}));
                checkOutput("memCtrl", 16'({a.memWe, a.memRe}), 16'({e.memWe, e.memRe}));
                checkOutput("wbCtrl", 16'({a.wbSel, a.wbWe, a.wbRd}),
                            16'({e.wbSel, e.wbWe, e.wbRd}));
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        phaseFwd = 1'b1;
        $display("[TB] forwarding instance");
        runDirected();
        runRandom(400);
        phaseFwd = 1'b0;
        $display("[TB] stall-only instance");
        runDirected();
        runRandom(400);
        repeat (3) @(posedge clk);
        checkOutput("drain", 16'(expQ.size()), 16'h0);
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/pipe_control.md
# pipe_control

Pipelined control unit for the 4-bit-opcode filter processor. It decodes the opcode in ID and carries the control word through ID/EX, EX/MEM and MEM/WB registers. It also detects RAW hazards, generates forwarding selects or stalls, and squashes wrong-path instructions on a taken BT. It sits between the instruction register and the datapath and drives the ALU, data memory and register file.

## Interface
Parameters:
- REG_AW, 4, register address width.
- FWD_EN, 1: 1 resolves RAW hazards by forwarding; 0 resolves them by stalling only.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- valid_i  in  1  ID holds a valid instruction.
- opcode_i  in  4  ID opcode.
- rd_i / ra_i / rb_i  in  REG_AW each  destination and source registers.
- br_cond_i  in  1  branch condition, evaluated in EX.
- re_a_o / re_b_o  out  1 each  ID register-file read enables (combinational).
- stall_o  out  1  hold PC and IF/ID.
- flush_o  out  1  squash IF/ID.
- illegal_o  out  1  ID opcode is 1001 or 1010 with valid_i=1 (combinational).
- ex_alu_ctrl  out  3  ALU control in EX.
- ex_sel_b  out  2  ALU operand-B select in EX.
- ex_fwd_a / ex_fwd_b  out  2 each  operand source: 0 = regfile, 1 = EX/MEM result, 2 = MEM/WB data.
- mem_we_o / mem_re_o  out  1 each  data-memory write and read enables in MEM.
- wb_sel_data  out  2  write-back mux select.
- wb_reg_we  out  1  register-file write enable.
- wb_rd  out  REG_AW  write-back destination register.

## Operation
Decode, when valid_i=1:
- 0xxx: ALU op, alu_ctrl=opcode[2:0], sel_b=0, sel_data=0, reg_we=1.
- 1000 CMP: alu_ctrl=001, reg_we=0.
- 1011 MOV: sel_data=1, reg_we=1.
- 1100 LD: sel_b=1, alu_ctrl=000, mem_re=1, sel_data=2, reg_we=1.
- 1101 ST: sel_b=2, alu_ctrl=000, mem_we=1, reg_we=0.
- 1110 BT: reg_we=0. 1111 NOP: all control fields 0.
- 1001 / 1010: decoded as NOP and illegal_o=1.
- re_a=0 for MOV, BT, NOP and illegal opcodes.
- re_b=0 for NOT (0110), MOV, LD, BT, NOP and illegal opcodes.

Bubble:
- A bubble is an all-zero control word with stage valid=0.
- Bubbled stages drive every control output to 0.

Hazard rules:
- A source matches a producer when the source read enable is set and the producer is valid, has reg_we=1 and has rd equal to that source.
- Load-use (FWD_EN=1): EX holds LD matching an ID source -> stall_o=1 for 1 cycle and a bubble enters EX.
- Forward (FWD_EN=1):
  - EX/MEM non-LD match -> fwd=1.
  - Otherwise MEM/WB match -> fwd=2.
  - EX/MEM has priority over MEM/WB.
  - Fwd selects are computed in ID and registered into ID/EX.
- FWD_EN=0:
  - Stall while any ID source matches EX or EX/MEM.
  - The register file is write-through, so a MEM/WB match does not stall.
  - Fwd outputs are tied to 0.
  - Maximum stall is 2 cycles.

Branch:
- EX holds BT and br_cond_i=1 -> flush_o=1 that cycle.
- The instruction in ID is replaced by a bubble into EX.
- IF/ID is squashed by the fetch stage.
- Penalty is 2 cycles.
- Flush overrides stall: stall_o=0 whenever flush_o=1.

While stall_o=1, the ID inputs are held by upstream and ID/EX receives a bubble. EX/MEM and MEM/WB keep advancing.

## Timing
- Reset (rst_n=0 at a rising edge): all stage valids, control registers, wb_rd and fwd selects become 0. stall_o=0 and flush_o=0 from the following cycle. In-flight instructions are dropped.
- Latency from ID decode to EX outputs is 1 cycle, to MEM is 2 cycles, to WB is 3 cycles.
- stall_o and flush_o are combinational from current stage state and ID inputs. They are valid within the same cycle.
- wb_reg_we, wb_rd and wb_sel_data are registered and stable for the whole WB cycle.

## Test plan
- Reset mid-stream: ADD, LD, ST in flight, rst_n=0 for 1 cycle -> all outputs 0 next cycle, no mem_we_o pulse.
- LD r3 then ADD r4,r3,r5 (FWD_EN=1) -> stall_o=1 for exactly 1 cycle, one bubble in EX, ADD reaches EX with ex_fwd_a=2.
- ADD r1 then SUB r2,r1,r1 then OR r6,r1,r2 -> SUB gets ex_fwd_a=ex_fwd_b=1. OR gets ex_fwd_a=2 and ex_fwd_b=1. No stall.
- Same ADD/SUB sequence with FWD_EN=0 -> stall_o=1 for 2 cycles, fwd outputs stay 0.
- BT in EX with br_cond_i=1 while ID holds LD matching a source -> flush_o=1, stall_o=0. No mem_re_o for the squashed LD. With br_cond_i=0 -> no flush.
- Opcode 1010 valid -> illegal_o=1, no reg_we or mem enables downstream. NOT, MOV and NOP give re_b_o=0. CMP gives wb_reg_we=0 in WB.
